imem_loadable: RTL and testbench

IMEM_LOADABLE -- requirements
Module: imem_loadable

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_ram.sv | 27 ++
 rtl/imem_loadable.sv | 142 ++++++++++++++
 tb/tb_imem_loadable.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the loadable instruction memory.
package imem_pkg;

  // Controller state: INIT sweeps the fill word through every location, RUN serves traffic.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } imem_state_e;

  // Right-shift that turns a fetch byte address into a word index.
  function automatic int word_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port-write, synchronous-read storage array. A read and a write to the
// same location in one cycle return the old contents (read-before-write).
module imem_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // NOTE: the array has no reset; the controller's INIT sweep gives it defined contents.
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port share the edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make the read see the pre-write value in a same-word collision.
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: after reset an INIT sweep fills every word with
// NOP_WORD, then RUN serves fetches (two-edge registered response) and program loads.
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per word
// and expose a parity_err output alongside each fetch response.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 32,
  parameter int                ADDR_W   = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = '0,
  localparam int               LA_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_fault,
  input  logic              load_we,
  input  logic [LA_W-1:0]   load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ack,
  output logic              ready
`ifdef IMEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef IMEM_PARITY_EN
  localparam int STORE_W = DATA_W + 1;
`else
  localparam int STORE_W = DATA_W;
`endif

  localparam int                SHIFT      = word_shift(DATA_W);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << SHIFT) - 1);
  localparam logic [ADDR_W:0]   DEPTH_A    = (ADDR_W + 1)'(DEPTH);
  localparam logic [LA_W:0]     DEPTH_L    = (LA_W + 1)'(DEPTH);

  // Stored word image: data plus, when enabled, an even-parity bit on top.
  function automatic logic [STORE_W-1:0] store_word(input logic [DATA_W-1:0] d);
`ifdef IMEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  imem_state_e        state, state_d;
  logic [LA_W:0]      sweep_cnt, sweep_d;
  logic               ram_we;
  logic [LA_W-1:0]    ram_waddr;
  logic [STORE_W-1:0] ram_wdata;
  logic               ram_re;
  logic [STORE_W-1:0] ram_rdata;
  logic [ADDR_W-1:0]  word_idx;
  logic               fetch_bad;
  logic               load_ok;
  logic               fetch_go;
  logic               load_go;
  logic               rd_pend;
  logic               fault_pend;

  assign ready     = (state == RUN);
  assign word_idx  = fetch_addr >> SHIFT;
  assign fetch_bad = ((fetch_addr & ALIGN_MASK) != '0) || ({1'b0, word_idx} >= DEPTH_A);
  assign load_ok   = ({1'b0, load_addr} < DEPTH_L);
  assign fetch_go  = ready && fetch_req;
  assign load_go   = ready && load_we && load_ok;
  assign ram_re    = fetch_go && !fetch_bad;

  // Next-state logic and write-port steering between the sweep and program loads.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state;
    sweep_d   = sweep_cnt;
    ram_we    = 1'b0;
    ram_waddr = load_addr;
    ram_wdata = store_word(load_data);
    case (state)
      INIT: begin
        if (sweep_cnt < DEPTH_L) begin
          ram_we    = reset;
          ram_waddr = sweep_cnt[LA_W-1:0];
          ram_wdata = store_word(NOP_WORD);
          sweep_d   = sweep_cnt + 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN:     ram_we  = load_go && reset;
      default: state_d = INIT;
    endcase
  end

  imem_ram #(
    .WIDTH (STORE_W),
    .DEPTH (DEPTH),
    .AW    (LA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (word_idx[LA_W-1:0]),
    .rdata (ram_rdata)
  );

  // State register, request pipeline and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= INIT;
      sweep_cnt   <= '0;
      rd_pend     <= 1'b0;
      fault_pend  <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_data  <= NOP_WORD;
      load_ack    <= 1'b0;
`ifdef IMEM_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      sweep_cnt   <= sweep_d;
      rd_pend     <= fetch_go;
      fault_pend  <= fetch_go && fetch_bad;
      fetch_valid <= rd_pend;
      fetch_fault <= rd_pend && fault_pend;
      if (rd_pend) fetch_data <= fault_pend ? NOP_WORD : ram_rdata[DATA_W-1:0];
      load_ack    <= load_go;
`ifdef IMEM_PARITY_EN
      parity_err  <= rd_pend && !fault_pend && (^ram_rdata);
`endif
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable with a response/ack scoreboard.
// Define IMEM_PARITY_EN to also exercise the parity-error path.
module tb_imem_loadable;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_valid;
  logic [15:0] fetch_data;
  logic        fetch_fault;
  logic        load_we;
  logic [4:0]  load_addr;
  logic [15:0] load_data;
  logic        load_ack;
  logic        ready;
`ifdef IMEM_PARITY_EN
  logic        parity_err;
`endif

  imem_loadable dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_fault (fetch_fault),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_ack    (load_ack),
    .ready       (ready)
`ifdef IMEM_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        fault;
    logic        perr;
    int          due;
  } resp_t;

  resp_t exp_q[$];
  int    ack_q[$];
  int    cyc      = 0;
  int    errors   = 0;
  int    checks   = 0;
  int    ack_seen = 0;
  bit    mon      = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then score any response or ack that is due or present.
  task automatic step();
    resp_t r;
    int    d;
    @(posedge clk);
    #1;
    cyc++;
    if (mon) begin
      if (fetch_valid === 1'b1 || (exp_q.size() > 0 && exp_q[0].due == cyc)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(fetch_valid), 32'd0);
        end else begin
          r = exp_q.pop_front();
          check("resp_valid", 32'(fetch_valid), 32'd1);
          check("resp_cycle", 32'(cyc), 32'(r.due));
          check("resp_data", 32'(fetch_data), 32'(r.data));
          check("resp_fault", 32'(fetch_fault), 32'(r.fault));
`ifdef IMEM_PARITY_EN
          check("resp_parity", 32'(parity_err), 32'(r.perr));
`endif
        end
      end
      if (load_ack === 1'b1 || (ack_q.size() > 0 && ack_q[0] == cyc)) begin
        if (load_ack === 1'b1) ack_seen++;
        if (ack_q.size() == 0) begin
          check("unexpected_ack", 32'(load_ack), 32'd0);
        end else begin
          d = ack_q.pop_front();
          check("ack", 32'(load_ack), 32'd1);
          check("ack_cycle", 32'(cyc), 32'(d));
        end
      end
    end
  endtask

  // Drive a fetch for the next edge; the response is due two edges later.
  task automatic issue_fetch(input logic [15:0] addr, input logic [15:0] data,
                             input logic fault, input logic perr);
    resp_t r;
    fetch_req  = 1'b1;
    fetch_addr = addr;
    r.data  = data;
    r.fault = fault;
    r.perr  = perr;
    r.due   = cyc + 2;
    exp_q.push_back(r);
  endtask

  // Drive a load for the next edge; the ack is due one edge later.
  task automatic issue_load(input logic [4:0] idx, input logic [15:0] data);
    load_we   = 1'b1;
    load_addr = idx;
    load_data = data;
    ack_q.push_back(cyc + 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && (exp_q.size() > 0 || ack_q.size() > 0); i++) step();
    if (exp_q.size() > 0 || ack_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size() + ack_q.size()), 32'd0);
      exp_q.delete();
      ack_q.delete();
    end
  endtask

  // Release reset and expect ready to rise on exactly the 33rd edge.
  task automatic sweep_after_release();
    reset = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      step();
      check("ready_sweep", 32'(ready), (i == 33) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 16'h000A;
    load_we    = 1'b1;
    load_addr  = 5'd5;
    load_data  = 16'hDEAD;

    // Reset with requests asserted: nothing may leak out.
    step();
    mon = 1'b1;
    step();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_data", 32'(fetch_data), 32'h0000);
    check("rst_ack", 32'(load_ack), 32'd0);

    // Requests stay asserted through the sweep and must be ignored.
    sweep_after_release();
    fetch_req = 1'b0;
    load_we   = 1'b0;

    issue_fetch(16'h0000, 16'h0000, 1'b0, 1'b0);
    step();
    fetch_req = 1'b0;
    issue_fetch(16'h000A, 16'h0000, 1'b0, 1'b0);
    step();
    fetch_req = 1'b0;
    drain();

    // Load word 5, then fetch it back.
    issue_load(5'd5, 16'h0564);
    step();
    load_we = 1'b0;
    drain();
    check("ack_count", 32'(ack_seen), 32'd1);
    issue_fetch(16'h000A, 16'h0564, 1'b0, 1'b0);
    step();
    fetch_req = 1'b0;
    drain();
    step();
    check("hold_data", 32'(fetch_data), 32'h0564);
    check("idle_valid", 32'(fetch_valid), 32'd0);

    // Back-to-back: misaligned, out of range, last word, good word, all-ones.
    issue_fetch(16'h0003, 16'h0000, 1'b1, 1'b0);
    step();
    issue_fetch(16'h0040, 16'h0000, 1'b1, 1'b0);
    step();
    issue_fetch(16'h003E, 16'h0000, 1'b0, 1'b0);
    step();
    issue_fetch(16'h000A, 16'h0564, 1'b0, 1'b0);
    step();
    issue_fetch(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    step();
    fetch_req = 1'b0;
    drain();
    step();
    check("idle_fault", 32'(fetch_fault), 32'd0);
    check("hold_nop", 32'(fetch_data), 32'h0000);

    // Same-word load and fetch in one cycle returns the old word.
    issue_load(5'd3, 16'h0EF2);
    step();
    load_we = 1'b0;
    drain();
    issue_load(5'd3, 16'hEFFF);
    issue_fetch(16'h0006, 16'h0EF2, 1'b0, 1'b0);
    step();
    load_we = 1'b0;
    issue_fetch(16'h0006, 16'hEFFF, 1'b0, 1'b0);
    step();
    fetch_req = 1'b0;
    drain();

    // Reset mid-run, then again mid-sweep at sweep_cnt = 10.
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("ready_partial", 32'(ready), 32'd0);
    end
    reset = 1'b0;
    step();
    check("ready_in_reset", 32'(ready), 32'd0);
    sweep_after_release();
    issue_fetch(16'h000A, 16'h0000, 1'b0, 1'b0);
    step();
    issue_fetch(16'h0006, 16'h0000, 1'b0, 1'b0);
    step();
    fetch_req = 1'b0;
    drain();

`ifdef IMEM_PARITY_EN
    // Corrupt one stored bit of word 7; word 6 stays clean.
    issue_load(5'd7, 16'h1234);
    step();
    load_we = 1'b0;
    drain();
    dut.u_ram.mem[7][3] = ~dut.u_ram.mem[7][3];
    issue_fetch(16'h000E, 16'h123C, 1'b0, 1'b1);
    step();
    issue_fetch(16'h000C, 16'h0000, 1'b0, 1'b0);
    step();
    issue_fetch(16'h000F, 16'h0000, 1'b1, 1'b0);
    step();
    fetch_req = 1'b0;
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
